// File: rtl/io_write_strobe_if.sv
// Bus-side signals of io_write_strobe: an asynchronous 68k write cycle in,
// one-hot write-clock pulses and captured data out to the register bank.
interface io_write_strobe_if #(
    parameter int NREG   = 8,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cpu_as_n;
    logic              cpu_ds_n;
    logic              cpu_rw;
    logic              cpu_sel;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic [NREG-1:0]   wr_c;
    logic [DATA_W-1:0] wr_d;
    logic              busy;

    modport master (
        output cpu_as_n, cpu_ds_n, cpu_rw, cpu_sel, cpu_addr, cpu_data,
        input  wr_c, wr_d, busy
    );

    modport slave (
        input  cpu_as_n, cpu_ds_n, cpu_rw, cpu_sel, cpu_addr, cpu_data,
        output wr_c, wr_d, busy
    );
endinterface

// File: rtl/io_write_strobe.sv
// Synchronises 68k write cycles into the clock domain and turns each accepted
// write into exactly one registered write-clock pulse plus stable data.
module io_write_strobe #(
    parameter int NREG       = 8,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int STROBE_LEN = 2
) (
    input  logic             clock,
    input  logic             reset,
    io_write_strobe_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for a selected write cycle on the synchronised strobes
    // STROBE | wr_c[idx] high while the counter runs down STROBE_LEN clocks
    // HOLD   | pulse done or address out of range; wait for AS/DS release
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CNT_W = 4;
    localparam logic [ADDR_W:0]  NREG_LIM = (ADDR_W + 1)'(NREG);
    localparam logic [CNT_W-1:0] LEN      = CNT_W'(STROBE_LEN);

    state_t            state_q, state_d;
    logic              as_meta_q, as_s_q;
    logic              ds_meta_q, ds_s_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wr_d_q, wr_d_d;
    logic [NREG-1:0]   wr_c_q, wr_c_d;
    logic              trigger;
    logic              in_range;

    // rw/sel/addr/data are only looked at while the synchronised strobes are
    // low, by which time the bus protocol guarantees they are stable.
    assign trigger  = !as_s_q && !ds_s_q && !bus.cpu_rw && bus.cpu_sel;
    assign in_range = {1'b0, bus.cpu_addr} < NREG_LIM;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            as_meta_q <= 1'b1;
            as_s_q    <= 1'b1;
            ds_meta_q <= 1'b1;
            ds_s_q    <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_d_q    <= '0;
            wr_c_q    <= '0;
        end else begin
            state_q   <= state_d;
            as_meta_q <= bus.cpu_as_n;
            as_s_q    <= as_meta_q;
            ds_meta_q <= bus.cpu_ds_n;
            ds_s_q    <= ds_meta_q;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_d_q    <= wr_d_d;
            wr_c_q    <= wr_c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d_d  = wr_d_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    if (in_range) begin
                        wr_d_d  = bus.cpu_data;
                        idx_d   = bus.cpu_addr[IDX_W-1:0];
                        cnt_d   = LEN;
                        state_d = STROBE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            STROBE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (as_s_q && ds_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decoding from the next state keeps wr_c a plain register output that is
    // high exactly while the FSM sits in STROBE.
    always_comb begin
        wr_c_d = '0;
        if (state_d == STROBE) begin
            wr_c_d[idx_d] = 1'b1;
        end
    end

    assign bus.wr_c = wr_c_q;
    assign bus.wr_d = wr_d_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: doc/io_write_strobe.md
# io_write_strobe

Bus-write front end for the I/O register bank. It synchronises asynchronous 68k bus write cycles into the `clock` domain and decodes the cycle address. For each accepted write it drives one clean, single write-clock pulse (`wr_c[i]`) plus stable data (`wr_d`) to the per-bit/per-byte `register` instances downstream. The pulse format (low, then high for `STROBE_LEN` clocks, then low) guarantees the downstream rising-edge detector sees exactly one edge per bus cycle, with data already stable.

## Interface
Parameters:
- `NREG`, default 8: number of strobe outputs / decoded register slots.
- `ADDR_W`, default 4: width of decoded address field; indices ≥ `NREG` are ignored.
- `DATA_W`, default 8: width of write data.
- `STROBE_LEN`, default 2: clocks each `wr_c` bit is held high (legal range 1..15).

Ports:
- `clock` in 1: single system clock; all state in this domain.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `cpu_as_n` in 1: 68k address strobe, async, active-low.
- `cpu_ds_n` in 1: data strobe (UDS/LDS combined upstream), async, active-low.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_sel` in 1: address window select from the main decoder, active-high.
- `cpu_addr` in `ADDR_W`: register index within the window.
- `cpu_data` in `DATA_W`: write data.
- `wr_c` out `NREG`: one-hot write-clock pulses to downstream registers.
- `wr_d` out `DATA_W`: captured write data, held until the next accepted write.
- `busy` out 1: high whenever FSM ≠ IDLE.

## Operation
- `cpu_as_n` and `cpu_ds_n` pass through 2-flop synchronisers (reset value 1). `as_s` and `ds_s` are the synchronised values.
- `cpu_rw`, `cpu_sel`, `cpu_addr`, and `cpu_data` are not synchronised. They are sampled only on the capture cycle, when they are guaranteed stable by bus protocol.
- FSM states: IDLE, STROBE, HOLD.
- **IDLE:**
  - Trigger condition: `as_s`=0 & `ds_s`=0 & `cpu_rw`=0 & `cpu_sel`=1.
  - On trigger with `cpu_addr` < `NREG`: capture `cpu_data`→`wr_d`, index→`idx`, load counter = `STROBE_LEN`, go to STROBE.
  - On trigger with `cpu_addr` ≥ `NREG`: go to HOLD. No strobe; `wr_d` is unchanged.
  - Read cycles and unselected cycles stay in IDLE.
- **STROBE:**
  - `wr_c` = one-hot(`idx`); all other bits 0.
  - Counter decrements each clock. When it reaches 1, go to HOLD; `wr_c` returns to 0 on entry to HOLD.
  - Bus signals are ignored here. A bus cycle that ends early does not shorten the pulse.
- **HOLD:**
  - `wr_c` = 0.
  - Wait for `as_s`=1 & `ds_s`=1, then go to IDLE.
  - This guarantees exactly one strobe per bus cycle, even when DS is held for many clocks.
- `wr_c` is registered (glitch-free). Exactly zero or one bit is high at any time.
- `wr_d` is registered and changes only on the capture edge.

## Timing
- Reset values: `wr_c`=0, `wr_d`=0, `busy`=0, state=IDLE, synchronisers=1, counter=0.
- Reset asserted mid-STROBE: `wr_c` drops to 0 asynchronously. After reset releases, the FSM is in IDLE. If the bus cycle is still active, it re-triggers (accepted behaviour).
- Latency: DS falling edge → `ds_s` low after 2 clock edges. The capture edge is the next edge, and `wr_c` rises on that same edge, so the strobe is high 3 clocks after DS falls (worst case +1 clock for edge alignment).
- `wr_d` updates on the same edge that `wr_c` rises. The downstream stage samples `d` one clock later, so data is stable ≥1 clock before sampling.
- `wr_c` high for exactly `STROBE_LEN` clocks. It is low for ≥1 clock before rising, since HOLD/IDLE always precede STROBE.
- Minimum spacing between two accepted writes: `STROBE_LEN` + 1 (HOLD) + 2 (sync of AS/DS deassert) + 2 (sync of next assert) clocks.
- `busy` goes high on the capture edge and low on the edge that enters IDLE.

## Test plan
- **Reset:** assert `reset` asynchronously during STROBE (`idx`=3) → `wr_c`=0 and `wr_d`=0 without waiting for a clock edge; `busy`=0 after release with bus idle.
- **Basic write:** `cpu_addr`=5, `cpu_data`=0xA5, `STROBE_LEN`=2, DS asserted 10 clocks → `wr_c`=0x20 for exactly 2 clocks starting 3 clocks after DS falls; `wr_d`=0xA5 on the same edge; single pulse only.
- **Out-of-range and reads:**
  - `cpu_addr`=9 with `NREG`=8 → no `wr_c` activity, `wr_d` unchanged, `busy` high until AS/DS deassert.
  - Read cycle (`cpu_rw`=1) → no activity at all.
- **Back-to-back writes:** addr 0 data 0x11, then addr 7 data 0x22, with 1-clock bus gaps → two pulses (`wr_c`=0x01, then 0x80), never overlapping. `wr_d` sequence is 0x11 then 0x22; a low gap exists between the pulses.
- **Early bus release:** DS/AS deasserted 1 clock after capture with `STROBE_LEN`=4 → `wr_c` still high for 4 clocks, then HOLD, then IDLE.
- **End-to-end with downstream `register` (`WIDTH`=8):** the instance at index 2 holds 0x3C after the write; the other instances are unchanged.
